// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared types and constants for the EX-stage hazard controller.
package ex_hazard_pkg;

  localparam int unsigned FWD_W = 2;

  typedef logic [FWD_W-1:0] fwd_sel_t;

  // Encoding matches the EX operand mux
  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_WB  = 2'b01;
  localparam fwd_sel_t FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

endpackage

// File: rtl/ex_hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: operand/rd info in, holds, flushes, selects out.
interface ex_hazard_ctrl_if #(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned REG_AW = 5
) ();
  import ex_hazard_pkg::*;

  logic [REG_AW-1:0] ID_rs1_addr;
  logic [REG_AW-1:0] ID_rs2_addr;
  logic              ID_rs1_used;
  logic              ID_rs2_used;
  logic [REG_AW-1:0] EX_rd_addr;
  logic              EX_rd_wren;
  logic              EX_mem_rden;
  logic [REG_AW-1:0] MEM_rd_addr;
  logic              MEM_rd_wren;
  logic              EX_br_sel;
  logic              i_mem_busy;

  fwd_sel_t          ID_forward_A;
  fwd_sel_t          ID_forward_B;
  logic              o_pc_hold;
  logic              o_ifid_hold;
  logic              o_idex_hold;
  logic              o_exmem_hold;
  logic              o_ifid_flush;
  logic              o_idex_flush;
  logic [CNT_W-1:0]  o_stall_cnt;
  logic [CNT_W-1:0]  o_flush_cnt;

  modport master (
    output ID_rs1_addr, ID_rs2_addr, ID_rs1_used, ID_rs2_used,
           EX_rd_addr, EX_rd_wren, EX_mem_rden, MEM_rd_addr, MEM_rd_wren,
           EX_br_sel, i_mem_busy,
    input  ID_forward_A, ID_forward_B, o_pc_hold, o_ifid_hold, o_idex_hold,
           o_exmem_hold, o_ifid_flush, o_idex_flush, o_stall_cnt, o_flush_cnt
  );

  modport slave (
    input  ID_rs1_addr, ID_rs2_addr, ID_rs1_used, ID_rs2_used,
           EX_rd_addr, EX_rd_wren, EX_mem_rden, MEM_rd_addr, MEM_rd_wren,
           EX_br_sel, i_mem_busy,
    output ID_forward_A, ID_forward_B, o_pc_hold, o_ifid_hold, o_idex_hold,
           o_exmem_hold, o_ifid_flush, o_idex_flush, o_stall_cnt, o_flush_cnt
  );

endinterface

// File: rtl/ex_hazard_ctrl_fwd_sel_calc.sv
// Per-operand forward select and load-use match for the instruction in ID.
module fwd_sel_calc
  import ex_hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] src_addr,
  input  logic              src_used,
  input  logic [REG_AW-1:0] ex_rd_addr,
  input  logic              ex_rd_wren,
  input  logic              ex_mem_rden,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic              mem_rd_wren,
  output fwd_sel_t          sel_c,
  output logic              ld_hit_c
);

  logic ex_hit;
  logic mem_hit;

  // x0 is never a real producer, so it never forwards
  assign ex_hit   = src_used & ex_rd_wren  & (ex_rd_addr  != '0) & (ex_rd_addr  == src_addr);
  assign mem_hit  = src_used & mem_rd_wren & (mem_rd_addr != '0) & (mem_rd_addr == src_addr);
  assign ld_hit_c = ex_hit & ex_mem_rden;

  // Younger producer in EX takes priority over MEM
  always_comb begin
    sel_c = FWD_RF;
    if (ex_hit && !ex_mem_rden) begin
      sel_c = FWD_MEM;
    end else if (mem_hit) begin
      sel_c = FWD_WB;
    end
  end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Hazard controller beside ID/EX: forward selects, load-use bubble, branch flush,
// memory-busy freeze and saturating stall/flush counters.
module ex_hazard_ctrl
  import ex_hazard_pkg::*;
#(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  ex_hazard_ctrl_if.slave hz
);

  hz_state_t        state_q;
  hz_state_t        state_d;
  fwd_sel_t         sel_a_c;
  fwd_sel_t         sel_b_c;
  logic             ld_a_c;
  logic             ld_b_c;
  logic             ldu_c;
  logic             freeze_c;
  logic             flush_c;
  logic             bubble_c;
  logic             hold_any_c;
  fwd_sel_t         fwd_a_q;
  fwd_sel_t         fwd_b_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  fwd_sel_calc #(.REG_AW(REG_AW)) u_fwd_a (
    .src_addr    (hz.ID_rs1_addr),
    .src_used    (hz.ID_rs1_used),
    .ex_rd_addr  (hz.EX_rd_addr),
    .ex_rd_wren  (hz.EX_rd_wren),
    .ex_mem_rden (hz.EX_mem_rden),
    .mem_rd_addr (hz.MEM_rd_addr),
    .mem_rd_wren (hz.MEM_rd_wren),
    .sel_c       (sel_a_c),
    .ld_hit_c    (ld_a_c)
  );

  fwd_sel_calc #(.REG_AW(REG_AW)) u_fwd_b (
    .src_addr    (hz.ID_rs2_addr),
    .src_used    (hz.ID_rs2_used),
    .ex_rd_addr  (hz.EX_rd_addr),
    .ex_rd_wren  (hz.EX_rd_wren),
    .ex_mem_rden (hz.EX_mem_rden),
    .mem_rd_addr (hz.MEM_rd_addr),
    .mem_rd_wren (hz.MEM_rd_wren),
    .sel_c       (sel_b_c),
    .ld_hit_c    (ld_b_c)
  );

  assign ldu_c = ld_a_c | ld_b_c;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // MEM_WAIT acts like RUN once busy drops, so a parked branch resolves on that cycle
  always_comb begin
    state_d  = state_q;
    freeze_c = 1'b0;
    flush_c  = 1'b0;
    bubble_c = 1'b0;
    case (state_q)
      RUN, MEM_WAIT: begin
        if (hz.i_mem_busy) begin
          freeze_c = 1'b1;
          state_d  = MEM_WAIT;
        end else if (hz.EX_br_sel) begin
          flush_c  = 1'b1;
          state_d  = RUN;
        end else if (ldu_c) begin
          bubble_c = 1'b1;
          state_d  = LD_STALL;
        end else begin
          state_d  = RUN;
        end
      end
      LD_STALL: begin
        if (hz.i_mem_busy) begin
          freeze_c = 1'b1;
          state_d  = MEM_WAIT;
        end else begin
          state_d  = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    if (!i_rst_n) begin
      freeze_c = 1'b0;
      flush_c  = 1'b0;
      bubble_c = 1'b0;
    end
  end

  assign hold_any_c = freeze_c | bubble_c;

  assign hz.o_pc_hold    = hold_any_c;
  assign hz.o_ifid_hold  = hold_any_c;
  assign hz.o_idex_hold  = freeze_c;
  assign hz.o_exmem_hold = freeze_c;
  assign hz.o_ifid_flush = flush_c;
  assign hz.o_idex_flush = flush_c | bubble_c;

  // Selects follow the instruction into EX; bubbles and flushed slots read the regfile
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else if (flush_c || bubble_c) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else if (!freeze_c) begin
      fwd_a_q <= sel_a_c;
      fwd_b_q <= sel_b_c;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(hold_any_c & ~(&stall_cnt_q));
      flush_cnt_q <= flush_cnt_q + CNT_W'(flush_c & ~(&flush_cnt_q));
    end
  end

  assign hz.ID_forward_A = fwd_a_q;
  assign hz.ID_forward_B = fwd_b_q;
  assign hz.o_stall_cnt  = stall_cnt_q;
  assign hz.o_flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl: directed hazard scenarios, then random traffic against a cycle model.
module tb_ex_hazard_ctrl;
  import ex_hazard_pkg::*;

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned REG_AW = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  ex_hazard_ctrl_if #(.CNT_W(CNT_W), .REG_AW(REG_AW)) hif ();

  ex_hazard_ctrl #(.CNT_W(CNT_W), .REG_AW(REG_AW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .hz      (hif)
  );

  always #5 clk = ~clk;

  // Reference state: what the pipeline should look like, tracked from the rules
  logic [1:0]       m_fa;
  logic [1:0]       m_fb;
  logic [CNT_W-1:0] m_stall;
  logic [CNT_W-1:0] m_flush;
  bit               m_after;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] ctl_vec();
    return {hif.o_pc_hold, hif.o_ifid_hold, hif.o_idex_hold,
            hif.o_exmem_hold, hif.o_ifid_flush, hif.o_idex_flush};
  endfunction

  function automatic logic [1:0] ref_sel(input logic [4:0] src, input logic used);
    if (used && src != 5'd0 && hif.EX_rd_wren && !hif.EX_mem_rden && hif.EX_rd_addr == src)
      return 2'b10;
    if (used && src != 5'd0 && hif.MEM_rd_wren && hif.MEM_rd_addr == src)
      return 2'b01;
    return 2'b00;
  endfunction

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2,
                        input logic [4:0] exrd, input logic exwr, input logic exld,
                        input logic [4:0] memrd, input logic memwr,
                        input logic br, input logic busy);
    hif.ID_rs1_addr = rs1;
    hif.ID_rs2_addr = rs2;
    hif.ID_rs1_used = u1;
    hif.ID_rs2_used = u2;
    hif.EX_rd_addr  = exrd;
    hif.EX_rd_wren  = exwr;
    hif.EX_mem_rden = exld;
    hif.MEM_rd_addr = memrd;
    hif.MEM_rd_wren = memwr;
    hif.EX_br_sel   = br;
    hif.i_mem_busy  = busy;
  endtask

  // One clock: check same-cycle controls, advance model, check registered outputs
  task automatic step(input string tag);
    logic       busy, ldu, frz, fl, st;
    logic [5:0] exp_ctl;
    #1;
    busy = hif.i_mem_busy;
    ldu  = hif.EX_mem_rden && hif.EX_rd_wren && hif.EX_rd_addr != 5'd0 &&
           ((hif.ID_rs1_used && hif.ID_rs1_addr == hif.EX_rd_addr) ||
            (hif.ID_rs2_used && hif.ID_rs2_addr == hif.EX_rd_addr));
    frz  = busy;
    fl   = !busy && !m_after && hif.EX_br_sel;
    st   = !busy && !m_after && !hif.EX_br_sel && ldu;
    exp_ctl = {frz | st, frz | st, frz, frz, fl, fl | st};
    check({tag, ":ctl"}, 64'(ctl_vec()), 64'(exp_ctl));
    if (fl || st) begin
      m_fa = 2'b00;
      m_fb = 2'b00;
    end else if (!frz) begin
      m_fa = ref_sel(hif.ID_rs1_addr, hif.ID_rs1_used);
      m_fb = ref_sel(hif.ID_rs2_addr, hif.ID_rs2_used);
    end
    if ((frz || st) && m_stall != {CNT_W{1'b1}}) m_stall = m_stall + 1;
    if (fl && m_flush != {CNT_W{1'b1}}) m_flush = m_flush + 1;
    if (!busy) m_after = st;
    @(posedge clk);
    #1;
    check({tag, ":fwdA"},  64'(hif.ID_forward_A), 64'(m_fa));
    check({tag, ":fwdB"},  64'(hif.ID_forward_B), 64'(m_fb));
    check({tag, ":stall"}, 64'(hif.o_stall_cnt),  64'(m_stall));
    check({tag, ":flush"}, 64'(hif.o_flush_cnt),  64'(m_flush));
    @(negedge clk);
  endtask

  initial begin
    m_fa = 2'b00; m_fb = 2'b00; m_stall = '0; m_flush = '0; m_after = 1'b0;

    // Reset: controls stay low even with busy and branch asserted
    set_in(5'd1, 5'd2, 1'b1, 1'b1, 5'd1, 1'b1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b1);
    #2;
    check("rst_ctl",   64'(ctl_vec()),        64'(6'b000000));
    check("rst_fwdA",  64'(hif.ID_forward_A), 64'(2'b00));
    check("rst_fwdB",  64'(hif.ID_forward_B), 64'(2'b00));
    check("rst_stall", 64'(hif.o_stall_cnt),  64'(0));
    check("rst_flush", 64'(hif.o_flush_cnt),  64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // add x5 in EX, ID reads rs1=x5
    set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    step("fwd_ex");
    check("fwd_ex_A", 64'(hif.ID_forward_A), 64'(2'b10));

    // lw x6 in EX, ID reads rs2=x6: one bubble, then retry forwards from WB
    set_in(5'd0, 5'd6, 1'b0, 1'b1, 5'd6, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("ldu_ctl_direct", 64'(ctl_vec()), 64'(6'b110001));
    step("ldu");
    check("ldu_stall_cnt", 64'(hif.o_stall_cnt), 64'(1));
    set_in(5'd0, 5'd6, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    step("ldu_retry");
    check("ldu_retry_B", 64'(hif.ID_forward_B), 64'(2'b01));
    check("ldu_once",    64'(hif.o_stall_cnt),  64'(1));

    // Taken branch with a simultaneous load-use: flush only
    set_in(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
    #1;
    check("br_ldu_ctl", 64'(ctl_vec()), 64'(6'b000011));
    step("br_ldu");
    check("br_flush_cnt", 64'(hif.o_flush_cnt), 64'(1));

    // Busy for 3 cycles with a branch parked in EX
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step("busy_br");
    check("busy_stall_cnt", 64'(hif.o_stall_cnt), 64'(4));
    check("busy_no_flush",  64'(hif.o_flush_cnt), 64'(1));
    hif.i_mem_busy = 1'b0;
    #1;
    check("busy_exit_ctl", 64'(ctl_vec()), 64'(6'b000011));
    step("busy_exit");
    check("busy_exit_flush", 64'(hif.o_flush_cnt), 64'(2));

    // x0 never forwards; EX beats MEM on a double match
    set_in(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    step("x0");
    check("x0_A", 64'(hif.ID_forward_A), 64'(2'b00));
    set_in(5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    step("ex_over_mem");
    check("ex_over_mem_B", 64'(hif.ID_forward_B), 64'(2'b10));

    // Stall counter saturation
    force dut.stall_cnt_q = {CNT_W{1'b1}};
    #1;
    release dut.stall_cnt_q;
    m_stall = {CNT_W{1'b1}};
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    step("sat");
    check("sat_hold", 64'(hif.o_stall_cnt), 64'({CNT_W{1'b1}}));
    hif.i_mem_busy = 1'b0;
    step("sat_idle");

    // Random traffic; EX carries a bubble while the load-use retry is pending
    for (int i = 0; i < 400; i++) begin
      logic bub;
      bub = m_after;
      set_in(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 7)),
             bub ? 1'b0 : 1'($urandom_range(0, 1)),
             bub ? 1'b0 : 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             bub ? 1'b0 : ($urandom_range(0, 6) == 0),
             ($urandom_range(0, 3) == 0));
      step("rand");
    end

    // Reset in the middle of a memory wait
    set_in(5'd2, 5'd2, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b1);
    step("wait1");
    step("wait2");
    rst_n = 1'b0;
    #1;
    check("midrst_ctl",   64'(ctl_vec()),        64'(6'b000000));
    check("midrst_fwdA",  64'(hif.ID_forward_A), 64'(2'b00));
    check("midrst_fwdB",  64'(hif.ID_forward_B), 64'(2'b00));
    check("midrst_stall", 64'(hif.o_stall_cnt),  64'(0));
    check("midrst_flush", 64'(hif.o_flush_cnt),  64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    m_fa = 2'b00; m_fb = 2'b00; m_stall = '0; m_flush = '0; m_after = 1'b0;
    hif.i_mem_busy = 1'b0;
    hif.EX_br_sel  = 1'b0;
    step("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_hazard_ctrl.md
Name: ex_hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage core. Sits beside the ID/EX boundary.
- Computes the registered forwarding selects that drive the EX operand muxes.
- Detects load-use hazards and inserts a 1-cycle bubble; flushes IF/ID and ID/EX on a taken branch from EX.
- Freezes the pipeline while data memory is busy, and keeps saturating stall/flush performance counters.

Parameters:
CNT_W, 32, width of the performance counters
REG_AW, 5, register address width

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, asynchronous, active-low
ID_rs1_addr  in  REG_AW  rs1 of instruction in ID
ID_rs2_addr  in  REG_AW  rs2 of instruction in ID
ID_rs1_used  in  1  ID instruction reads rs1
ID_rs2_used  in  1  ID instruction reads rs2
EX_rd_addr  in  REG_AW  rd of instruction in EX
EX_rd_wren  in  1  EX instruction writes rd
EX_mem_rden  in  1  EX instruction is a load
MEM_rd_addr  in  REG_AW  rd of instruction in MEM
MEM_rd_wren  in  1  MEM instruction writes rd
EX_br_sel  in  1  taken branch/jump resolved in EX
i_mem_busy  in  1  data memory not ready; hold the pipeline
ID_forward_A  out  2  registered operand-A forward select, valid while the instruction is in EX
ID_forward_B  out  2  registered operand-B forward select
o_pc_hold  out  1  hold PC
o_ifid_hold  out  1  hold the IF/ID register
o_idex_hold  out  1  hold the ID/EX register
o_exmem_hold  out  1  hold the EX/MEM register
o_ifid_flush  out  1  clear the IF/ID register
o_idex_flush  out  1  load a bubble into ID/EX
o_stall_cnt  out  CNT_W  cycles spent in LD_STALL or MEM_WAIT
o_flush_cnt  out  CNT_W  taken-branch flush events

Behaviour:
- Forward encoding, same as the EX mux: 00 register file, 01 WB_wb_data, 10 MEM_alu_data, 11 register file (unused).
- Per source operand, a combinational next-select is computed for the ID instruction.
  - 10 if the operand is used, EX_rd_wren=1, EX_mem_rden=0, EX_rd_addr!=0 and EX_rd_addr equals the source address.
  - Otherwise 01 if the operand is used, MEM_rd_wren=1, MEM_rd_addr!=0 and MEM_rd_addr equals the source address.
  - Otherwise 00. EX match has priority over MEM match.
- Load-use hazard (ldu) = EX_mem_rden & EX_rd_wren & EX_rd_addr!=0 & (rs1 match & rs1_used | rs2 match & rs2_used).
- FSM states: RUN, LD_STALL, MEM_WAIT. Reset state is RUN.
  - RUN: i_mem_busy -> MEM_WAIT. Else EX_br_sel -> flush, stay RUN. Else ldu -> LD_STALL. Else RUN.
  - LD_STALL: lasts exactly 1 cycle, then -> RUN, or -> MEM_WAIT if i_mem_busy. The load is now in MEM, so the retried ID instruction picks select 01.
  - MEM_WAIT: stay while i_mem_busy. Exit to RUN the cycle after i_mem_busy drops.
- Outputs during ldu detection in RUN (combinational):
  - o_pc_hold=1, o_ifid_hold=1, o_idex_flush=1.
  - Forward registers load 00 with the bubble.
- Outputs on flush (RUN & EX_br_sel & !i_mem_busy):
  - o_ifid_flush=1, o_idex_flush=1.
  - Forward registers load 00.
  - o_flush_cnt increments.
- Taken branch wins over ldu in the same cycle: no stall, only the flush.
- Outputs in MEM_WAIT, or in RUN with i_mem_busy=1:
  - All four hold outputs are 1; flushes are 0.
  - Forward registers hold.
  - EX_br_sel is ignored. The branch stays in EX and is acted on in the first non-busy cycle.
- Forward registers: update with the next-select only when ID/EX advances normally (no hold, no flush).
- o_stall_cnt increments every cycle in which any hold output is 1.
- Both counters saturate at all-ones and never wrap.
- Reset, including mid-stall or mid-wait:
  - state=RUN, ID_forward_A/B=00, counters=0.
  - Holds and flushes are deasserted while i_rst_n=0.
- Latency: forward selects appear 1 cycle after the ID decision. Holds and flushes are same-cycle combinational.

Decomposition:
- Package ex_hazard_pkg holds:
  - state typedef {RUN, LD_STALL, MEM_WAIT};
  - forward select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
- One sub-module, fwd_sel_calc (combinational per-operand select and match logic), instantiated twice for A and B.

Test Plan:
- add x5 in EX, ID reads rs1=x5 -> next cycle ID_forward_A=10, no hold.
- lw x6 in EX, ID reads rs2=x6:
  - o_pc_hold=o_ifid_hold=o_idex_flush=1 for exactly 1 cycle, o_stall_cnt=1;
  - retried instruction gets ID_forward_B=01.
- EX_br_sel=1 with a simultaneous ldu -> o_ifid_flush=o_idex_flush=1, no hold, o_flush_cnt=1, forwards=00.
- i_mem_busy high 3 cycles with EX_br_sel=1:
  - all holds=1 for 3 cycles, o_stall_cnt=3;
  - flush fires on the 4th cycle.
- EX writes x0 and ID reads x0 -> forward 00. EX and MEM both match x7 -> select 10.
- Counter preloaded to all-ones via force, one more stall -> stays all-ones. Assert i_rst_n=0 mid MEM_WAIT -> all outputs zero immediately.
